// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: mode/sequencing controller for an HH:MM:SS clock built from chained counters.
// Ports:
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_tick_1hz                1 Hz timebase pulse
//   i_sec_tick, i_min_tick    seconds/minutes counter carry ticks
//   i_btn_mode                debounced mode button pulse
//   i_btn_inc                 debounced increment button level
//   o_sec_en/o_min_en/o_hr_en registered counter enables
//   o_sec_srst                registered seconds-counter sync clear
//   o_mode                    0=RUN 1=SET_HH 2=SET_MM 3=SET_SS
//   o_blink                   blink phase for the selected field
// Optional feature: define CLOCK_SET_CTRL_BLINK_EN to build the blink flop; otherwise o_blink is tied 0.
module clock_set_ctrl #(
    parameter int REPEAT_DLY = 25_000_000,
    parameter int REPEAT_PER = 5_000_000,
    parameter int REPEAT_W   = 25,
    parameter int TIMEOUT_S  = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_tick_1hz,
    input  logic       i_sec_tick,
    input  logic       i_min_tick,
    input  logic       i_btn_mode,
    input  logic       i_btn_inc,
    output logic       o_sec_en,
    output logic       o_min_en,
    output logic       o_hr_en,
    output logic       o_sec_srst,
    output logic [1:0] o_mode,
    output logic       o_blink
);
    localparam int TW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {RUN = 2'd0, SET_HH = 2'd1, SET_MM = 2'd2, SET_SS = 2'd3} state_t;

    state_t                state, state_n;
    logic                  inc_d, armed;
    logic [REPEAT_W-1:0]   rpt;
    logic [TW-1:0]         tmo;
    logic                  in_set, rise, inc_pulse, timeout;

    // armed marks a press whose rising edge was seen in SET; a button still held
    // across a mode change stays unarmed until it is released and pressed again
    always_comb begin
        in_set    = state != RUN;
        rise      = i_btn_inc & ~inc_d;
        inc_pulse = in_set & ~i_btn_mode & i_btn_inc & (rise | (armed & rpt == '0));
        timeout   = in_set & i_tick_1hz & ~i_btn_mode & ~rise & ~inc_pulse
                    & (tmo == TW'(TIMEOUT_S - 1));
        state_n   = i_btn_mode ? state_t'(state + 2'd1) : timeout ? RUN : state;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            state <= RUN;
        else
            state <= state_n;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            inc_d      <= 1'b0;
            armed      <= 1'b0;
            rpt        <= '0;
            tmo        <= '0;
            o_sec_en   <= 1'b0;
            o_min_en   <= 1'b0;
            o_hr_en    <= 1'b0;
            o_sec_srst <= 1'b0;
        end else begin
            inc_d <= i_btn_inc;
            if (!in_set || i_btn_mode || !i_btn_inc) begin
                armed <= 1'b0;
                rpt   <= '0;
            end else if (rise) begin
                armed <= 1'b1;
                rpt   <= REPEAT_W'(REPEAT_DLY - 1);
            end else if (armed) begin
                rpt   <= (rpt == '0) ? REPEAT_W'(REPEAT_PER - 1) : rpt - 1'b1;
            end
            tmo <= (!in_set || i_btn_mode || rise || inc_pulse || timeout) ? '0 :
                   i_tick_1hz ? tmo + 1'b1 : tmo;
            // routing decided on the current state, so a carry in the leaving-RUN cycle still passes
            o_sec_en   <= !in_set && i_tick_1hz;
            o_min_en   <= in_set ? (state == SET_MM && inc_pulse) : i_sec_tick;
            o_hr_en    <= in_set ? (state == SET_HH && inc_pulse) : i_min_tick;
            o_sec_srst <= state == SET_SS && inc_pulse;
        end
    end

`ifdef CLOCK_SET_CTRL_BLINK_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            o_blink <= 1'b0;
        else
            o_blink <= (state_n == RUN) ? 1'b0 : inc_pulse ? 1'b1 : i_tick_1hz ? ~o_blink : o_blink;
    end
`else
    assign o_blink = 1'b0;
`endif

    assign o_mode = state;

endmodule
